// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/writeback over a
// shared datapath with one memory port, and owns ALU decode, the illegal trap and instret.
module multicycle_control #(
  parameter int ALUCTRL_W     = 3,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          Instr,
  input  logic                 EQ,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic [1:0]           ALUsrcA,
  output logic [1:0]           ALUsrcB,
  output logic [ALUCTRL_W-1:0] ALUctrl,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [CNT_W-1:0]     instret,
  output logic                 retire,
  output logic                 illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JAL,
    S_BRANCH,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  state_t     state;
  aluop_t     aluop;
  logic [2:0] alu_code;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       mem_ok;
  logic       unused_instr_bits;

  assign op       = Instr[6:0];
  assign funct3   = Instr[14:12];
  assign funct7b5 = Instr[30];
  assign mem_ok   = MEM_HANDSHAKE ? mem_ready : 1'b1;

  assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

  // NOTE: clocked state is assigned with <= only, so every branch below sees the
  // pre-edge state and the combinational decode (which uses =) stays race-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      instret <= '0;
      illegal <= 1'b0;
    end else begin
      if (retire) instret <= instret + CNT_W'(1);
      case (state)
        S_FETCH:    if (mem_ok) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXECR;
            OP_ITYPE:          state <= S_EXECI;
            OP_JAL:            state <= S_JAL;
            OP_BRANCH:         state <= S_BRANCH;
            default: begin
              state   <= S_TRAP;
              illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR:   state <= (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ok) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ok) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_JAL:      state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH: begin
          // Only beq/bne are supported; other branch encodings trap without retiring.
          if (funct3[2:1] == 2'b00) begin
            state <= S_FETCH;
          end else begin
            state   <= S_TRAP;
            illegal <= 1'b1;
          end
        end
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    retire    = 1'b0;
    ALUsrcA   = 2'b00;
    ALUsrcB   = 2'b00;
    ResultSrc = 2'b00;
    ImmSrc    = 2'b00;
    aluop     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUsrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ok;
        PCWrite   = mem_ok;
      end
      S_DECODE: begin
        // Branch/jump target is precomputed into ALUOut while the opcode is decoded.
        ALUsrcA = 2'b01;
        ALUsrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? 2'b11 : 2'b10;
      end
      S_MEMADR: begin
        ALUsrcA = 2'b10;
        ALUsrcB = 2'b01;
        ImmSrc  = (op == OP_STORE) ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = mem_ok;
      end
      S_EXECR: begin
        ALUsrcA = 2'b10;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUsrcA = 2'b10;
        ALUsrcB = 2'b01;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_JAL: begin
        ALUsrcA = 2'b01;
        ALUsrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUsrcA = 2'b10;
        aluop   = ALUOP_SUB;
        if (funct3 == 3'b000)      PCWrite = EQ;
        else if (funct3 == 3'b001) PCWrite = !EQ;
        retire = (funct3[2:1] == 2'b00);
      end
      default: ;
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      retire   = 1'b0;
    end
  end

  always_comb begin
    alu_code = 3'b000;
    case (aluop)
      ALUOP_SUB: alu_code = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_code = (funct7b5 && op[5]) ? 3'b001 : 3'b000;
          3'b010:  alu_code = 3'b101;
          3'b110:  alu_code = 3'b011;
          3'b111:  alu_code = 3'b010;
          default: alu_code = 3'b000;
        endcase
      end
      default: alu_code = 3'b000;
    endcase
  end

  assign ALUctrl = ALUCTRL_W'(alu_code);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected output schedules drive a queue that a
// single compare process checks every cycle, plus directed literal checks on key cycles.
module tb_multicycle_control;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef struct packed {
    logic        pcwrite;
    logic        irwrite;
    logic        adrsrc;
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    logic [1:0]  srca;
    logic [1:0]  srcb;
    logic [2:0]  aluctrl;
    logic [1:0]  resultsrc;
    logic [1:0]  immsrc;
    logic        retire;
    logic        illegal;
    logic [31:0] instret;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        eq_flag = 1'b0;
  logic        mem_ready = 1'b0;

  logic        pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, retire, illegal;
  logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0]  alu_ctrl;
  logic [31:0] instret;

  logic        s_pc_write, s_ir_write, s_adr_src, s_mem_read, s_mem_write, s_reg_write;
  logic        s_retire, s_illegal;
  logic [1:0]  s_alu_src_a, s_alu_src_b, s_result_src, s_imm_src;
  logic [2:0]  s_alu_ctrl;
  logic [3:0]  s_instret;

  always #5 clk = ~clk;

  multicycle_control #(.ALUCTRL_W(3), .MEM_HANDSHAKE(1'b1), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .Instr(instr), .EQ(eq_flag), .mem_ready(mem_ready),
    .PCWrite(pc_write), .IRWrite(ir_write), .AdrSrc(adr_src), .MemRead(mem_read),
    .MemWrite(mem_write), .RegWrite(reg_write), .ALUsrcA(alu_src_a), .ALUsrcB(alu_src_b),
    .ALUctrl(alu_ctrl), .ResultSrc(result_src), .ImmSrc(imm_src), .instret(instret),
    .retire(retire), .illegal(illegal)
  );

  multicycle_control #(.ALUCTRL_W(3), .MEM_HANDSHAKE(1'b1), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .Instr(instr), .EQ(eq_flag), .mem_ready(mem_ready),
    .PCWrite(s_pc_write), .IRWrite(s_ir_write), .AdrSrc(s_adr_src), .MemRead(s_mem_read),
    .MemWrite(s_mem_write), .RegWrite(s_reg_write), .ALUsrcA(s_alu_src_a),
    .ALUsrcB(s_alu_src_b), .ALUctrl(s_alu_ctrl), .ResultSrc(s_result_src),
    .ImmSrc(s_imm_src), .instret(s_instret), .retire(s_retire), .illegal(s_illegal)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cnt = '0;
  bit          ill = 1'b0;
  int          stop_left = -1;
  exp_t        exp_q[$];
  bit          full_q[$];
  exp_t        hist[$];
  exp_t        m_en, m_regwrite, m_memwrite, m_adrsrc, m_retire, m_illegal;
  exp_t        ce, cw, ca, cs, cm;
  bit          cf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, want);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e = '0;
    e.instret = cnt;
    e.illegal = ill;
    return e;
  endfunction

  function automatic exp_t actual_big();
    exp_t a;
    a = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, alu_src_a, alu_src_b,
         alu_ctrl, result_src, imm_src, retire, illegal, instret};
    return a;
  endfunction

  function automatic exp_t actual_small();
    exp_t a;
    a = {s_pc_write, s_ir_write, s_adr_src, s_mem_read, s_mem_write, s_reg_write, s_alu_src_a,
         s_alu_src_b, s_alu_ctrl, s_result_src, s_imm_src, s_retire, s_illegal, 28'd0, s_instret};
    return a;
  endfunction

  // ALU operation required for a funct-decoded R/I instruction.
  function automatic logic [2:0] alu_ref(input logic [31:0] ins);
    case (ins[14:12])
      3'b000:  return (ins[30] && ins[5]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int last_count(input int n, input exp_t m);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if ((hist[hist.size() - 1 - i] & m) != '0) c++;
    return c;
  endfunction

  task automatic cyc(input logic [31:0] ins, input logic mr, input logic eq, input exp_t e);
    if (stop_left == 0) return;
    if (stop_left > 0) stop_left--;
    @(negedge clk);
    rst = 1'b0;
    instr = ins;
    mem_ready = mr;
    eq_flag = eq;
    exp_q.push_back(e);
    full_q.push_back(1'b1);
    if (e.retire) cnt = cnt + 32'd1;
  endtask

  task automatic reset_cycle();
    exp_t z;
    z = '0;
    @(negedge clk);
    rst = 1'b1;
    instr = $urandom;
    mem_ready = 1'($urandom);
    eq_flag = 1'($urandom);
    exp_q.push_back(z);
    full_q.push_back(1'b0);
    cnt = '0;
    ill = 1'b0;
    stop_left = -1;
  endtask

  task automatic trap_cycles(input int n);
    exp_t e;
    ill = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = blank();
      cyc($urandom, 1'($urandom), 1'($urandom), e);
    end
  endtask

  // Expected schedule of one instruction: fw/mw are the not-ready cycles in fetch / data access.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic eq);
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    for (int i = 0; i <= fw; i++) begin
      e = blank();
      e.memread = 1'b1;
      e.srcb = 2'b10;
      e.resultsrc = 2'b10;
      e.irwrite = (i == fw);
      e.pcwrite = (i == fw);
      cyc($urandom, (i == fw), 1'($urandom), e);
    end
    e = blank();
    e.srca = 2'b01;
    e.srcb = 2'b01;
    e.immsrc = (op == OP_JAL) ? 2'b11 : 2'b10;
    cyc(ins, 1'($urandom), 1'($urandom), e);
    case (op)
      OP_LW, OP_SW: begin
        e = blank();
        e.srca = 2'b10;
        e.srcb = 2'b01;
        e.immsrc = (op == OP_SW) ? 2'b01 : 2'b00;
        cyc(ins, 1'($urandom), 1'($urandom), e);
        for (int i = 0; i <= mw; i++) begin
          e = blank();
          e.adrsrc = 1'b1;
          if (op == OP_LW) e.memread = 1'b1;
          else begin
            e.memwrite = 1'b1;
            e.retire = (i == mw);
          end
          cyc(ins, (i == mw), 1'($urandom), e);
        end
        if (op == OP_LW) begin
          e = blank();
          e.resultsrc = 2'b01;
          e.regwrite = 1'b1;
          e.retire = 1'b1;
          cyc(ins, 1'($urandom), 1'($urandom), e);
        end
      end
      OP_R, OP_I, OP_JAL: begin
        e = blank();
        if (op == OP_JAL) begin
          e.srca = 2'b01;
          e.srcb = 2'b10;
          e.pcwrite = 1'b1;
        end else begin
          e.srca = 2'b10;
          e.srcb = (op == OP_I) ? 2'b01 : 2'b00;
          e.aluctrl = alu_ref(ins);
        end
        cyc(ins, 1'($urandom), 1'($urandom), e);
        e = blank();
        e.regwrite = 1'b1;
        e.retire = 1'b1;
        cyc(ins, 1'($urandom), 1'($urandom), e);
      end
      OP_BR: begin
        e = blank();
        e.srca = 2'b10;
        e.aluctrl = 3'b001;
        if (f3 == 3'b000 || f3 == 3'b001) begin
          e.pcwrite = (f3 == 3'b000) ? eq : !eq;
          e.retire = 1'b1;
        end
        cyc(ins, 1'($urandom), eq, e);
        if (!(f3 == 3'b000 || f3 == 3'b001)) trap_cycles(12);
      end
      default: trap_cycles(12);
    endcase
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 8))
      0: r[6:0] = OP_LW;
      1: r[6:0] = OP_SW;
      2: begin
        r[6:0] = OP_R;
        if (r[31]) r[14:12] = 3'b000;
      end
      3: r[6:0] = OP_I;
      4: r[6:0] = OP_JAL;
      5: begin r[6:0] = OP_BR; r[14:12] = 3'b000; end
      6: begin r[6:0] = OP_BR; r[14:12] = 3'b001; end
      7: r[6:0] = OP_BR;
      default: ;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      cf = full_q.pop_front();
      ca = actual_big();
      cs = actual_small();
      hist.push_back(ca);
      cm = cf ? '1 : m_en;
      cw = ce;
      cw.instret = {28'd0, ce.instret[3:0]};
      check("cycle_outputs", 64'(ca & cm), 64'(ce & cm));
      check("cycle_outputs_cnt4", 64'(cs & cm), 64'(cw & cm));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    m_en = '0;
    m_en.pcwrite = 1'b1; m_en.irwrite = 1'b1; m_en.memread = 1'b1;
    m_en.memwrite = 1'b1; m_en.regwrite = 1'b1; m_en.retire = 1'b1;
    m_regwrite = '0; m_regwrite.regwrite = 1'b1;
    m_memwrite = '0; m_memwrite.memwrite = 1'b1;
    m_adrsrc   = '0; m_adrsrc.adrsrc = 1'b1;
    m_retire   = '0; m_retire.retire = 1'b1;
    m_illegal  = '0; m_illegal.illegal = 1'b1;

    reset_cycle();
    reset_cycle();
    @(posedge clk); #1;
    check("reset_instret", 64'(instret), 64'(0));
    check("reset_illegal", 64'(illegal), 64'(0));

    run_instr(32'h00412083, 0, 0, 1'b0);
    #3;
    check("lw_wb_regwrite", 64'(hist[$].regwrite), 64'(1));
    check("lw_wb_resultsrc", 64'(hist[$].resultsrc), 64'(2'b01));
    check("lw_single_regwrite", 64'(last_count(5, m_regwrite)), 64'(1));
    @(posedge clk); #1;
    check("lw_instret", 64'(instret), 64'(1));

    run_instr(32'h402081B3, 0, 0, 1'b0);
    #3;
    check("sub_aluctrl", 64'(hist[$-1].aluctrl), 64'(3'b001));
    check("sub_regwrite_c4", 64'(hist[$].regwrite), 64'(1));
    run_instr(32'h002081B3, 0, 0, 1'b0);
    #3;
    check("add_aluctrl", 64'(hist[$-1].aluctrl), 64'(3'b000));

    run_instr(32'h00208463, 0, 0, 1'b1);
    #3;
    check("beq_taken_pcwrite", 64'(hist[$].pcwrite), 64'(1));
    check("beq_retire", 64'(hist[$].retire), 64'(1));
    run_instr(32'h00208463, 0, 0, 1'b0);
    #3;
    check("beq_not_taken_pcwrite", 64'(hist[$].pcwrite), 64'(0));
    run_instr(32'h00209463, 0, 0, 1'b0);
    #3;
    check("bne_taken_pcwrite", 64'(hist[$].pcwrite), 64'(1));

    run_instr(32'h00112023, 0, 3, 1'b0);
    #3;
    check("sw_memwrite_held", 64'(last_count(4, m_memwrite)), 64'(4));
    check("sw_adrsrc_held", 64'(last_count(4, m_adrsrc)), 64'(4));
    check("sw_no_regwrite", 64'(last_count(7, m_regwrite)), 64'(0));
    check("sw_retire_last", 64'(hist[$].retire), 64'(1));
    check("sw_single_retire", 64'(last_count(4, m_retire)), 64'(1));
    @(posedge clk); #1;
    check("instret_after_7", 64'(instret), 64'(7));

    stop_left = 5;
    run_instr(32'h00412083, 0, 3, 1'b0);
    reset_cycle();
    #3;
    check("abort_no_regwrite", 64'(last_count(6, m_regwrite)), 64'(0));
    @(posedge clk); #1;
    check("abort_instret_cleared", 64'(instret), 64'(0));

    run_instr(32'h00000000, 1, 0, 1'b0);
    #3;
    check("trap_illegal", 64'(hist[$].illegal), 64'(1));
    check("trap_illegal_sticky", 64'(last_count(12, m_illegal)), 64'(12));
    check("trap_no_enables", 64'(last_count(12, m_en)), 64'(0));
    reset_cycle();
    @(posedge clk); #1;
    check("trap_cleared_by_rst", 64'(illegal), 64'(0));

    for (int k = 0; k < 16; k++) run_instr(32'h00208463, 0, 0, 1'($urandom));
    @(posedge clk); #1;
    check("instret_16", 64'(instret), 64'(16));
    check("instret_w4_wrap", 64'(s_instret), 64'(0));

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 19) == 0) stop_left = $urandom_range(1, 5);
      run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
      if (ill || stop_left >= 0) reset_cycle();
    end

    @(negedge clk); #3;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
